// File: rtl/marv32_decode_feed_ctrl_pkg.sv
// Shared types and constants for the decode feed controller slice.
package marv32_decode_feed_ctrl_pkg;

   localparam int XLEN = 32;

   // addi x0, x0, 0 -- what the decoder sees when no real instruction is available
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   // RUN: no stale responses outstanding; DRAIN: wrong-path responses still to arrive
   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } feed_state_t;

   // One buffered fetch response (64 bits: instruction word + its PC)
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/marv32_decode_feed_ctrl_if.sv
// Fetch-side and decode-side signals of the decode feed controller.
//
// Handshake semantics:
//   fetch_req_allow_out is a credit: fetch_req_in may only be 1 in a cycle where allow is 1,
//   and the request is taken at that rising edge. fetch_rsp_valid_in has no back-pressure,
//   every response is taken at the edge it is presented. dec_valid_out is the valid and
//   !stall_in the ready of the decode side: the head instruction transfers at the edge
//   where both are 1. redirect_in overrides everything in its cycle.
interface marv32_decode_feed_ctrl_if;
   import marv32_decode_feed_ctrl_pkg::*;

   logic            fetch_req_allow_out;
   logic            fetch_req_in;
   logic            fetch_rsp_valid_in;
   logic [XLEN-1:0] fetch_rsp_instr_in;
   logic [XLEN-1:0] fetch_rsp_pc_in;
   logic            redirect_in;
   logic            stall_in;
   logic            dec_valid_out;
   logic [XLEN-1:0] dec_instr_out;
   logic [XLEN-1:0] dec_pc_out;
   logic            dec_flush_out;
   logic            drain_busy_out;
   feed_state_t     state_dbg;

   // Controller side
   modport slave (
      input  fetch_req_in, fetch_rsp_valid_in, fetch_rsp_instr_in, fetch_rsp_pc_in,
      input  redirect_in, stall_in,
      output fetch_req_allow_out, dec_valid_out, dec_instr_out, dec_pc_out,
      output dec_flush_out, drain_busy_out, state_dbg
   );

   // Fetch unit / pipeline side
   modport master (
      output fetch_req_in, fetch_rsp_valid_in, fetch_rsp_instr_in, fetch_rsp_pc_in,
      output redirect_in, stall_in,
      input  fetch_req_allow_out, dec_valid_out, dec_instr_out, dec_pc_out,
      input  dec_flush_out, drain_busy_out, state_dbg
   );

endinterface

// File: rtl/marv32_decode_feed_ctrl_skid_fifo.sv
// Instruction buffer: DEPTH entries of {instr, pc}. No internal flow control; the
// owner guarantees no push when full and no pop when empty. clear empties it at once.
module marv32_decode_feed_ctrl_skid_fifo
   import marv32_decode_feed_ctrl_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       clear,
   input  logic                       push,
   input  fetch_entry_t               push_data,
   input  logic                       pop,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output fetch_entry_t               head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int BUF_W = $clog2(DEPTH+1);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;

   // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else if (clear) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (push) tail_ptr <= tail_ptr + PTR_W'(1);
         if (pop)  head_ptr <= head_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + BUF_W'(1);
         else if (pop && !push) count <= count - BUF_W'(1);
      end
   end

   // Storage write; contents need no reset because count gates their use
   always_ff @(posedge clk_in) begin
      if (push && !clear) mem[tail_ptr] <= push_data;
   end

   assign head = mem[head_ptr];

endmodule

// File: rtl/marv32_decode_feed_ctrl.sv
// Feeds fetched instructions into the decoder: issues fetch credits, buffers responses,
// presents the buffer head each cycle and discards wrong-path responses after a redirect.
module marv32_decode_feed_ctrl
#(
   parameter int          DEPTH           = 2,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] NOP_INSTR       = marv32_decode_feed_ctrl_pkg::NOP_INSTR
) (
   input logic                        clk_in,
   input logic                        rst_in,
   marv32_decode_feed_ctrl_if.slave   bus
);
   import marv32_decode_feed_ctrl_pkg::*;

   localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
   localparam int BUF_W = $clog2(DEPTH+1);

   logic [CNT_W-1:0] live_cnt;
   logic [CNT_W-1:0] stale_cnt;
   logic [CNT_W-1:0] live_nxt;
   logic [CNT_W-1:0] stale_nxt;
   feed_state_t      state;
   logic [BUF_W-1:0] count;
   fetch_entry_t     head;
   fetch_entry_t     rsp_entry;
   logic             rsp_live;
   logic             dec_valid;
   logic             pop;

   // A response belongs to the current path only when nothing stale is still due
   assign rsp_live  = bus.fetch_rsp_valid_in && (stale_cnt == '0) && !bus.redirect_in;
   assign dec_valid = (count != '0) && !bus.redirect_in;
   assign pop       = dec_valid && !bus.stall_in;
   assign rsp_entry = '{instr: bus.fetch_rsp_instr_in, pc: bus.fetch_rsp_pc_in};

   marv32_decode_feed_ctrl_skid_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .clear     (bus.redirect_in),
      .push      (rsp_live),
      .push_data (rsp_entry),
      .pop       (pop),
      .count     (count),
      .head      (head)
   );

   // Credits: a live request always has a buffer slot reserved, and total in-flight is capped
   assign bus.fetch_req_allow_out =
      ((int'(count) + int'(live_cnt)) < DEPTH) &&
      ((int'(live_cnt) + int'(stale_cnt)) < MAX_OUTSTANDING);

   // Next live/stale counts; a redirect turns every outstanding request into a stale one
   always_comb begin
      live_nxt  = live_cnt;
      stale_nxt = stale_cnt;
      if (bus.redirect_in) begin
         stale_nxt = stale_cnt + live_cnt - CNT_W'(bus.fetch_rsp_valid_in);
         live_nxt  = CNT_W'(bus.fetch_req_in);
      end else begin
         if (bus.fetch_rsp_valid_in && (stale_cnt != '0)) stale_nxt = stale_cnt - CNT_W'(1);
         live_nxt = live_cnt + CNT_W'(bus.fetch_req_in) - CNT_W'(rsp_live);
      end
   end

   // Counters and RUN/DRAIN state; DRAIN whenever stale responses remain outstanding
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         live_cnt  <= '0;
         stale_cnt <= '0;
         state     <= RUN;
      end else begin
         live_cnt  <= live_nxt;
         stale_cnt <= stale_nxt;
         state     <= (stale_nxt != '0) ? DRAIN : RUN;
      end
   end

   assign bus.dec_valid_out  = dec_valid;
   assign bus.dec_flush_out  = !dec_valid;
   assign bus.dec_instr_out  = dec_valid ? head.instr : NOP_INSTR;
   assign bus.dec_pc_out     = dec_valid ? head.pc : '0;
   assign bus.drain_busy_out = (state == DRAIN);
   assign bus.state_dbg      = state;

   // The credit rule must leave room for every live response
   a_no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
      !(rsp_live && !pop && (count == BUF_W'(DEPTH))));

   // Requests only under credit, responses only for something in flight
   a_req_legal: assert property (@(posedge clk_in) disable iff (rst_in)
      !(bus.fetch_req_in && !bus.fetch_req_allow_out));
   a_rsp_expected: assert property (@(posedge clk_in) disable iff (rst_in)
      !(bus.fetch_rsp_valid_in && (live_cnt == '0) && (stale_cnt == '0)));

endmodule

// File: tb/tb_marv32_decode_feed_ctrl.sv
// Directed bench for marv32_decode_feed_ctrl (DEPTH=2, MAX_OUTSTANDING=2).
// Inputs change and outputs are sampled just after the falling edge.
`timescale 1ns/1ps
module tb_marv32_decode_feed_ctrl;
   import marv32_decode_feed_ctrl_pkg::*;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   int   total  = 0;
   int   bad    = 0;

   marv32_decode_feed_ctrl_if bus ();

   marv32_decode_feed_ctrl #(
      .DEPTH           (2),
      .MAX_OUTSTANDING (2),
      .NOP_INSTR       (32'h0000_0013)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   // Clock: 10 ns period
   always #5 clk_in = ~clk_in;

   task automatic drive(input logic req, input logic rv, input logic [31:0] instr,
                        input logic [31:0] pc, input logic redir, input logic stall);
      @(negedge clk_in);
      bus.fetch_req_in       = req;
      bus.fetch_rsp_valid_in = rv;
      bus.fetch_rsp_instr_in = instr;
      bus.fetch_rsp_pc_in    = pc;
      bus.redirect_in        = redir;
      bus.stall_in           = stall;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [31:0] instr,
                          input logic [31:0] pc, input logic allow, input logic drain);
      chk({tag, ".valid"}, 32'(bus.dec_valid_out), 32'(v));
      chk({tag, ".flush"}, 32'(bus.dec_flush_out), 32'(!v));
      chk({tag, ".instr"}, bus.dec_instr_out, instr);
      chk({tag, ".pc"},    bus.dec_pc_out, pc);
      chk({tag, ".allow"}, 32'(bus.fetch_req_allow_out), 32'(allow));
      chk({tag, ".drain"}, 32'(bus.drain_busy_out), 32'(drain));
      chk({tag, ".state"}, 32'(bus.state_dbg), drain ? 32'(DRAIN) : 32'(RUN));
   endtask

   initial begin
      bus.fetch_req_in       = 1'b0;
      bus.fetch_rsp_valid_in = 1'b0;
      bus.fetch_rsp_instr_in = '0;
      bus.fetch_rsp_pc_in    = '0;
      bus.redirect_in        = 1'b0;
      bus.stall_in           = 1'b0;

      // Reset held for 3 cycles
      repeat (3) @(posedge clk_in);
      @(negedge clk_in); #1;
      chk_out("reset", 1'b0, NOP, 32'h0, 1'b1, 1'b0);
      rst_in = 1'b0;

      // Stream: response one cycle after each request
      drive(1, 0, 32'h0, 32'h0, 0, 0);               chk_out("s0", 0, NOP, 32'h0, 1, 0);
      drive(1, 1, 32'h12345678, 32'h100, 0, 0);      chk_out("s1", 0, NOP, 32'h0, 1, 0);
      drive(0, 1, 32'h1234567c, 32'h104, 0, 0);      chk_out("s2", 1, 32'h12345678, 32'h100, 0, 0);
      drive(1, 0, 32'h0, 32'h0, 0, 0);               chk_out("s3", 1, 32'h1234567c, 32'h104, 1, 0);
      drive(1, 1, 32'h12345680, 32'h108, 0, 0);      chk_out("s4", 0, NOP, 32'h0, 1, 0);
      drive(0, 1, 32'h12345684, 32'h10c, 0, 0);      chk_out("s5", 1, 32'h12345680, 32'h108, 0, 0);
      drive(0, 0, 32'h0, 32'h0, 0, 0);               chk_out("s6", 1, 32'h12345684, 32'h10c, 1, 0);

      // Stall with two buffered entries, then release
      drive(1, 0, 32'h0, 32'h0, 0, 1);               chk_out("t0", 0, NOP, 32'h0, 1, 0);
      drive(1, 1, 32'haaaa0001, 32'h200, 0, 1);      chk_out("t1", 0, NOP, 32'h0, 1, 0);
      drive(0, 1, 32'haaaa0002, 32'h204, 0, 1);      chk_out("t2", 1, 32'haaaa0001, 32'h200, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 32'h0, 32'h0, 0, 1);            chk_out("t3", 1, 32'haaaa0001, 32'h200, 0, 0);
      end
      drive(0, 0, 32'h0, 32'h0, 0, 0);               chk_out("t4", 1, 32'haaaa0001, 32'h200, 0, 0);
      drive(0, 0, 32'h0, 32'h0, 0, 0);               chk_out("t5", 1, 32'haaaa0002, 32'h204, 1, 0);
      drive(0, 0, 32'h0, 32'h0, 0, 0);               chk_out("t6", 0, NOP, 32'h0, 1, 0);

      // Redirect with one buffered and one live request outstanding
      drive(1, 0, 32'h0, 32'h0, 0, 0);               chk_out("r0", 0, NOP, 32'h0, 1, 0);
      drive(1, 1, 32'hbbbb0001, 32'h300, 0, 0);      chk_out("r1", 0, NOP, 32'h0, 1, 0);
      drive(0, 0, 32'h0, 32'h0, 1, 0);               chk_out("r2", 0, NOP, 32'h0, 0, 0);
      drive(1, 1, 32'hdead0000, 32'h304, 0, 0);      chk_out("r3", 0, NOP, 32'h0, 1, 1);
      drive(0, 1, 32'hbbbb0002, 32'h400, 0, 0);      chk_out("r4", 0, NOP, 32'h0, 1, 0);
      drive(0, 0, 32'h0, 32'h0, 0, 0);               chk_out("r5", 1, 32'hbbbb0002, 32'h400, 1, 0);
      drive(0, 0, 32'h0, 32'h0, 0, 0);               chk_out("r6", 0, NOP, 32'h0, 1, 0);

      // Redirect with two live requests: two stale responses dropped
      drive(1, 0, 32'h0, 32'h0, 0, 0);               chk_out("q0", 0, NOP, 32'h0, 1, 0);
      drive(1, 0, 32'h0, 32'h0, 0, 0);               chk_out("q1", 0, NOP, 32'h0, 1, 0);
      drive(0, 0, 32'h0, 32'h0, 1, 0);               chk_out("q2", 0, NOP, 32'h0, 0, 0);
      drive(0, 1, 32'hdead0001, 32'h308, 0, 0);      chk_out("q3", 0, NOP, 32'h0, 0, 1);
      drive(1, 1, 32'hdead0002, 32'h30c, 0, 0);      chk_out("q4", 0, NOP, 32'h0, 1, 1);
      drive(0, 1, 32'hcccc0001, 32'h500, 0, 0);      chk_out("q5", 0, NOP, 32'h0, 1, 0);
      drive(0, 0, 32'h0, 32'h0, 0, 0);               chk_out("q6", 1, 32'hcccc0001, 32'h500, 1, 0);

      // Redirect together with a response and a stall
      drive(1, 0, 32'h0, 32'h0, 0, 0);               chk_out("p0", 0, NOP, 32'h0, 1, 0);
      drive(1, 1, 32'hdddd0001, 32'h600, 0, 0);      chk_out("p1", 0, NOP, 32'h0, 1, 0);
      drive(0, 1, 32'hdddd0002, 32'h604, 1, 1);      chk_out("p2", 0, NOP, 32'h0, 0, 0);
      drive(0, 0, 32'h0, 32'h0, 0, 0);               chk_out("p3", 0, NOP, 32'h0, 1, 0);

      // Request issued in the redirect cycle is new-path and gets delivered
      drive(1, 0, 32'h0, 32'h0, 0, 0);               chk_out("v0", 0, NOP, 32'h0, 1, 0);
      drive(1, 0, 32'h0, 32'h0, 1, 0);               chk_out("v1", 0, NOP, 32'h0, 1, 0);
      drive(0, 1, 32'hdead0003, 32'h310, 0, 0);      chk_out("v2", 0, NOP, 32'h0, 0, 1);
      drive(0, 1, 32'heeee0001, 32'h700, 0, 0);      chk_out("v3", 0, NOP, 32'h0, 1, 0);
      drive(0, 0, 32'h0, 32'h0, 0, 0);               chk_out("v4", 1, 32'heeee0001, 32'h700, 1, 0);

      // Reset asserted while draining (stale=1, live=1)
      drive(1, 0, 32'h0, 32'h0, 0, 0);               chk_out("u0", 0, NOP, 32'h0, 1, 0);
      drive(1, 0, 32'h0, 32'h0, 1, 0);               chk_out("u1", 0, NOP, 32'h0, 1, 0);
      drive(0, 0, 32'h0, 32'h0, 0, 0);               chk_out("u2", 0, NOP, 32'h0, 0, 1);
      @(negedge clk_in);
      rst_in = 1'b1;
      #1;
      chk_out("u3", 0, NOP, 32'h0, 1, 0);
      @(negedge clk_in);
      rst_in = 1'b0;
      #1;
      chk_out("u4", 0, NOP, 32'h0, 1, 0);

      // Clean transaction after reset: counters really cleared
      drive(1, 0, 32'h0, 32'h0, 0, 0);               chk_out("w0", 0, NOP, 32'h0, 1, 0);
      drive(0, 1, 32'hffff0001, 32'h900, 0, 0);      chk_out("w1", 0, NOP, 32'h0, 1, 0);
      drive(0, 0, 32'h0, 32'h0, 0, 0);               chk_out("w2", 1, 32'hffff0001, 32'h900, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
